// File: rtl/fifo_stream_pkg.sv
// -----------------------------------------------------------------------------
// fifo_stream_pkg
// Shared definitions for the FIFO stream sink and the matching stream source:
// sink state encoding, default widths, and the LFSR constants and step
// function used for pseudo-random throttling.
// Optional feature macro: FIFO_STREAM_SINK_LFSR_THROTTLE_EN (users of
// lfsr_step live behind it; the package itself is always compiled whole).
// -----------------------------------------------------------------------------
package fifo_stream_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 16;
    localparam int DEF_THR_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sink_state_e;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 -> bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/fifo_stream_throttle.sv
// -----------------------------------------------------------------------------
// fifo_stream_throttle
// Registered handshake-throttle generator. A load captures the pattern and
// presents bit 0 on the following cycle; each enabled cycle after that walks
// the pointer through the pattern, wrapping at THR_W-1. With neither load nor
// enable the output drops to 0 on the next edge. The output is a pure
// register, so no input reaches rdy_o combinationally.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_ni     asynchronous active-low reset
//   load_i     capture pattern_i and restart the rotation
//   enable_i   advance the rotation for one more cycle
//   pattern_i  THR_W-bit pattern, bit i = ready in cycle i of the rotation
//   rdy_o      registered ready/valid throttle output
//
// Optional feature macro: FIFO_STREAM_SINK_LFSR_THROTTLE_EN. When defined, a
// zero pattern at load selects bit 0 of a free-running LFSR instead.
// -----------------------------------------------------------------------------
module fifo_stream_throttle
    import fifo_stream_pkg::*;
#(
    parameter int THR_W = DEF_THR_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             enable_i,
    input  logic [THR_W-1:0] pattern_i,
    output logic             rdy_o
);

    localparam int PTR_W = (THR_W > 1) ? $clog2(THR_W) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(THR_W - 1);
    // Bit 0 is consumed by the load itself, so the rotation resumes at 1.
    localparam logic [PTR_W-1:0] PTR_START = PTR_W'((THR_W > 1) ? 1 : 0);

    logic [THR_W-1:0] pattern_q, pattern_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             rdy_q, rdy_d;
`ifdef FIFO_STREAM_SINK_LFSR_THROTTLE_EN
    logic [15:0]      lfsr_q, lfsr_d;
    logic             lfsr_mode_q, lfsr_mode_d;
`endif

    always_comb begin
        pattern_d = pattern_q;
        ptr_d     = ptr_q;
        rdy_d     = 1'b0;
`ifdef FIFO_STREAM_SINK_LFSR_THROTTLE_EN
        lfsr_d      = lfsr_q;
        lfsr_mode_d = lfsr_mode_q;
`endif
        if (load_i) begin
            pattern_d = pattern_i;
            ptr_d     = PTR_START;
            rdy_d     = pattern_i[0];
`ifdef FIFO_STREAM_SINK_LFSR_THROTTLE_EN
            lfsr_mode_d = (pattern_i == '0);
            lfsr_d      = lfsr_step(LFSR_SEED);
            if (pattern_i == '0) begin
                rdy_d = LFSR_SEED[0];
            end
`endif
        end else if (enable_i) begin
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
            rdy_d = pattern_q[ptr_q];
`ifdef FIFO_STREAM_SINK_LFSR_THROTTLE_EN
            lfsr_d = lfsr_step(lfsr_q);
            if (lfsr_mode_q) begin
                rdy_d = lfsr_q[0];
            end
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pattern_q <= '0;
            ptr_q     <= '0;
            rdy_q     <= 1'b0;
`ifdef FIFO_STREAM_SINK_LFSR_THROTTLE_EN
            lfsr_q      <= '0;
            lfsr_mode_q <= 1'b0;
`endif
        end else begin
            pattern_q <= pattern_d;
            ptr_q     <= ptr_d;
            rdy_q     <= rdy_d;
`ifdef FIFO_STREAM_SINK_LFSR_THROTTLE_EN
            lfsr_q      <= lfsr_d;
            lfsr_mode_q <= lfsr_mode_d;
`endif
        end
    end

    assign rdy_o = rdy_q;

endmodule

// File: rtl/fifo_stream_sink.sv
// -----------------------------------------------------------------------------
// fifo_stream_sink
// Read-side consumer/checker for a FIFO ready-valid stream. Accepts a run of
// num_beats beats with a programmable ready throttle, compares every accepted
// beat against an incrementing expected value starting at first_val, and
// reports beat count, saturating error count and the first mismatching data.
//
// Ports:
//   clk             clock, rising edge
//   reset           asynchronous active-low reset
//   start           one-cycle run request (honoured in IDLE or DONE only)
//   num_beats       beats in the run, sampled on start (0 = finish at once)
//   first_val       expected value of the first beat, sampled on start
//   thr_pattern     ready rotation pattern, sampled on start
//   data_out        stream data
//   data_out_vld    stream valid
//   data_out_rdy    stream ready (registered)
//   busy            high while running
//   done            high after a run until the next start
//   beat_cnt        accepted beats this run
//   err_cnt         mismatching beats this run, saturating
//   first_err_data  data of the first mismatching beat, 0 if none
//
// Optional feature macro: FIFO_STREAM_SINK_LFSR_THROTTLE_EN (LFSR-driven
// ready when thr_pattern is zero; handled inside fifo_stream_throttle).
// -----------------------------------------------------------------------------
module fifo_stream_sink
    import fifo_stream_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int THR_W  = DEF_THR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_beats,
    input  logic [DATA_W-1:0] first_val,
    input  logic [THR_W-1:0]  thr_pattern,
    input  logic [DATA_W-1:0] data_out,
    input  logic              data_out_vld,
    output logic              data_out_rdy,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [DATA_W-1:0] first_err_data
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    sink_state_e       state_q, state_d;
    logic [CNT_W-1:0]  nbeats_q, nbeats_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic [DATA_W-1:0] ferr_q, ferr_d;
    logic              thr_load, thr_enable, rdy;
    logic              xfer;

    assign xfer = (state_q == RUN) && data_out_vld && rdy;

    always_comb begin
        state_d  = state_q;
        nbeats_d = nbeats_q;
        beat_d   = beat_q;
        err_d    = err_q;
        exp_d    = exp_q;
        ferr_d   = ferr_q;
        thr_load = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    nbeats_d = num_beats;
                    exp_d    = first_val;
                    beat_d   = '0;
                    err_d    = '0;
                    ferr_d   = '0;
                    thr_load = (num_beats != '0);
                    state_d  = (num_beats == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (xfer) begin
                    beat_d = beat_q + CNT_W'(1);
                    // No resync: a bad beat still advances the expectation.
                    exp_d  = exp_q + DATA_W'(1);
                    if (data_out != exp_q) begin
                        err_d = sat_inc(err_q);
                        if (err_q == '0) begin
                            ferr_d = data_out;
                        end
                    end
                    if (beat_q + CNT_W'(1) == nbeats_q) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Ready keeps rotating only while the run continues, so it drops
        // the cycle after the final beat.
        thr_enable = (state_q == RUN) && (state_d == RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            nbeats_q <= '0;
            beat_q   <= '0;
            err_q    <= '0;
            exp_q    <= '0;
            ferr_q   <= '0;
        end else begin
            state_q  <= state_d;
            nbeats_q <= nbeats_d;
            beat_q   <= beat_d;
            err_q    <= err_d;
            exp_q    <= exp_d;
            ferr_q   <= ferr_d;
        end
    end

    fifo_stream_throttle #(
        .THR_W (THR_W)
    ) u_throttle (
        .clk_i     (clk),
        .rst_ni    (reset),
        .load_i    (thr_load),
        .enable_i  (thr_enable),
        .pattern_i (thr_pattern),
        .rdy_o     (rdy)
    );

    assign data_out_rdy   = rdy;
    assign busy           = (state_q == RUN);
    assign done           = (state_q == DONE);
    assign beat_cnt       = beat_q;
    assign err_cnt        = err_q;
    assign first_err_data = ferr_q;

endmodule

// File: tb/tb_fifo_stream_sink.sv
// -----------------------------------------------------------------------------
// tb_fifo_stream_sink
// Directed bench for fifo_stream_sink: a bench-side FIFO model presents an
// incrementing stream (optionally with one corrupted beat) and advances on
// each observed handshake. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_fifo_stream_sink;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] num_beats;
    logic [7:0]  first_val;
    logic [7:0]  thr_pattern;
    logic [7:0]  data_out;
    logic        data_out_vld;
    logic        data_out_rdy;
    logic        busy;
    logic        done;
    logic [15:0] beat_cnt;
    logic [15:0] err_cnt;
    logic [7:0]  first_err_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_stream_sink dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .num_beats      (num_beats),
        .first_val      (first_val),
        .thr_pattern    (thr_pattern),
        .data_out       (data_out),
        .data_out_vld   (data_out_vld),
        .data_out_rdy   (data_out_rdy),
        .busy           (busy),
        .done           (done),
        .beat_cnt       (beat_cnt),
        .err_cnt        (err_cnt),
        .first_err_data (first_err_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the start edge.
    task automatic pulse_start(input logic [15:0] nb, input logic [7:0] fv, input logic [7:0] pat);
        num_beats   = nb;
        first_val   = fv;
        thr_pattern = pat;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // FIFO model: always valid, beat k carries base+k except beat bad_idx.
    // Records ready per cycle; stops after n beats or budget cycles.
    task automatic stream(input int n, input logic [7:0] base, input int bad_idx,
                          input logic [7:0] bad_val, input int budget,
                          output int got, output int cyc, output logic [31:0] rdy_bits);
        logic xf;
        got      = 0;
        cyc      = 0;
        rdy_bits = '0;
        data_out_vld = 1'b1;
        data_out     = (bad_idx == 0) ? bad_val : base;
        while (got < n && cyc < budget) begin
            @(negedge clk);
            if (cyc < 32) rdy_bits[cyc] = data_out_rdy;
            xf = data_out_vld && data_out_rdy;
            @(posedge clk);
            #1;
            cyc++;
            if (xf) begin
                got++;
                data_out = (got == bad_idx) ? bad_val : base + got[7:0];
            end
        end
        data_out_vld = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rdy"},  {31'd0, data_out_rdy}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy},         32'd0);
        check({tag, "_done"}, {31'd0, done},         32'd0);
        check({tag, "_beat"}, {16'd0, beat_cnt},     32'd0);
        check({tag, "_err"},  {16'd0, err_cnt},      32'd0);
        check({tag, "_ferr"}, {24'd0, first_err_data}, 32'd0);
    endtask

    initial begin
        int          got, cyc;
        logic [31:0] rb;
        logic        rdy_seen;

        reset        = 1'b0;
        start        = 1'b0;
        num_beats    = '0;
        first_val    = '0;
        thr_pattern  = '0;
        data_out     = '0;
        data_out_vld = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Valid while idle must not count
        data_out_vld = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        data_out_vld = 1'b0;
        check("idle_vld_beat", {16'd0, beat_cnt}, 32'd0);
        check("idle_vld_rdy",  {31'd0, data_out_rdy}, 32'd0);

        // Basic run: 16 beats, ready always high
        pulse_start(16'd16, 8'h00, 8'hFF);
        check("basic_busy", {31'd0, busy}, 32'd1);
        stream(16, 8'h00, -1, 8'h00, 100, got, cyc, rb);
        check("basic_got",   got, 32'd16);
        check("basic_cyc",   cyc, 32'd16);
        check("basic_rdy",   rb, 32'h0000FFFF);
        check("basic_done",  {31'd0, done}, 32'd1);
        check("basic_busy2", {31'd0, busy}, 32'd0);
        check("basic_rdy_after", {31'd0, data_out_rdy}, 32'd0);
        check("basic_beat",  {16'd0, beat_cnt}, 32'd16);
        check("basic_err",   {16'd0, err_cnt}, 32'd0);
        check("basic_ferr",  {24'd0, first_err_data}, 32'd0);

        // Throttle 0x55: 8 beats over 15 cycles, alternating from high
        pulse_start(16'd8, 8'h00, 8'h55);
        stream(8, 8'h00, -1, 8'h00, 100, got, cyc, rb);
        check("thr_got",  got, 32'd8);
        check("thr_cyc",  cyc, 32'd15);
        check("thr_rdy",  rb, 32'h00005555);
        check("thr_beat", {16'd0, beat_cnt}, 32'd8);
        check("thr_err",  {16'd0, err_cnt}, 32'd0);
        check("thr_done", {31'd0, done}, 32'd1);

        // Error capture with an ignored start in the middle of the run
        pulse_start(16'd4, 8'h10, 8'hFF);
        pulse_start(16'd2, 8'h40, 8'hFF);
        check("ign_busy", {31'd0, busy}, 32'd1);
        check("ign_beat", {16'd0, beat_cnt}, 32'd0);
        stream(4, 8'h10, 2, 8'h77, 100, got, cyc, rb);
        check("err_got",  got, 32'd4);
        check("err_beat", {16'd0, beat_cnt}, 32'd4);
        check("err_err",  {16'd0, err_cnt}, 32'd1);
        check("err_ferr", {24'd0, first_err_data}, 32'h77);
        check("err_done", {31'd0, done}, 32'd1);

        // Wrap 0xFE..0x01
        pulse_start(16'd4, 8'hFE, 8'hFF);
        check("wrap_ferr_cleared", {24'd0, first_err_data}, 32'd0);
        stream(4, 8'hFE, -1, 8'h00, 100, got, cyc, rb);
        check("wrap_beat", {16'd0, beat_cnt}, 32'd4);
        check("wrap_err",  {16'd0, err_cnt}, 32'd0);
        check("wrap_done", {31'd0, done}, 32'd1);

        // num_beats = 0: DONE next cycle, counters cleared, ready never high
        data_out_vld = 1'b1;
        pulse_start(16'd0, 8'h00, 8'hFF);
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_busy", {31'd0, busy}, 32'd0);
        check("zero_beat", {16'd0, beat_cnt}, 32'd0);
        rdy_seen = data_out_rdy;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rdy_seen = rdy_seen | data_out_rdy;
        end
        data_out_vld = 1'b0;
        @(posedge clk);
        #1;
        check("zero_rdy",   {31'd0, rdy_seen}, 32'd0);
        check("zero_beat2", {16'd0, beat_cnt}, 32'd0);

        // Reset mid-run after 5 of 10 beats
        pulse_start(16'd10, 8'h20, 8'hFF);
        stream(5, 8'h20, -1, 8'h00, 100, got, cyc, rb);
        check("mid_beat", {16'd0, beat_cnt}, 32'd5);
        check("mid_busy", {31'd0, busy}, 32'd1);
        #3;
        reset = 1'b0;
        #1;
        check_all_zero("midrst");
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        pulse_start(16'd10, 8'h30, 8'hFF);
        stream(10, 8'h30, -1, 8'h00, 100, got, cyc, rb);
        check("fresh_got",  got, 32'd10);
        check("fresh_beat", {16'd0, beat_cnt}, 32'd10);
        check("fresh_err",  {16'd0, err_cnt}, 32'd0);
        check("fresh_done", {31'd0, done}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fifo_stream_sink.md
Name: fifo_stream_sink

Overview:
- Consumer and checker on the FIFO read side.
- Terminates the data_out/data_out_vld/data_out_rdy ready-valid stream, drives data_out_rdy with a programmable throttle pattern, and checks every accepted beat against an expected incrementing sequence.
- Reports beat count, error count and first mismatch; used as the DUT-side sink in block-level and top-level benches.

Parameters:
- DATA_W, 8, width of data_out and of the expected-value counter.
- CNT_W, 16, width of num_beats, beat_cnt and err_cnt.
- THR_W, 8, length of the ready throttle pattern in cycles.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a run; ignored unless state is IDLE or DONE.
- num_beats  input  CNT_W  beats to consume in the run, sampled on start; 0 = completes immediately.
- first_val  input  DATA_W  expected value of first beat, sampled on start.
- thr_pattern  input  THR_W  ready pattern, bit i = ready in cycle i of rotation, sampled on start.
- data_out  input  DATA_W  stream data from FIFO.
- data_out_vld  input  1  stream valid from FIFO.
- data_out_rdy  output  1  stream ready to FIFO.
- busy  output  1  high in RUN.
- done  output  1  high in DONE until next start.
- beat_cnt  output  CNT_W  accepted beats this run.
- err_cnt  output  CNT_W  mismatching beats this run, saturating.
- first_err_data  output  DATA_W  data of first mismatching beat; 0 if none.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE.
  - All outputs 0, including data_out_rdy, beat_cnt, err_cnt, first_err_data.
  - Expected counter, throttle pointer and registered inputs are cleared.
- States:
  - IDLE: data_out_rdy=0. start -> RUN, or DONE if num_beats=0.
  - RUN: data_out_rdy = thr_pattern[ptr]. ptr increments every cycle, wrapping at THR_W-1 -> 0. On the accepting beat where beat_cnt reaches num_beats -> DONE.
  - DONE: data_out_rdy=0; counters hold. start -> RUN with all counters cleared.
- Handshake:
  - A beat transfers when data_out_vld && data_out_rdy on a rising clk edge.
  - data_out_rdy is registered: a function of state and ptr only, never of data_out_vld. No combinational path from inputs to data_out_rdy.
  - data_out_rdy deasserts in the cycle after the last beat is accepted. At most one beat is accepted per cycle, so there is no overshoot.
- Check on each transfer:
  - Compare data_out against exp.
  - Mismatch: err_cnt increments, saturating at all-ones. If err_cnt was 0, first_err_data = data_out.
  - exp always advances to exp+1, modulo 2^DATA_W, wrapping 0xFF->0x00 at default width.
  - The checker does not resynchronise on the received value.
- beat_cnt increments per transfer; latency from transfer to updated counters is 1 cycle.
- thr_pattern=0 in RUN: ready never asserts and the block waits indefinitely. This is legal; the bench owns timeouts.
- start while busy: ignored.
- data_out_vld while not RUN: no transfer, no count.
- reset asserted mid-run: immediate return to IDLE; partial counts are discarded.

Optional Feature:
- Macro: FIFO_STREAM_SINK_LFSR_THROTTLE_EN.
- Defined:
  - When thr_pattern==0 at start, data_out_rdy is driven from bit 0 of a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 loaded on start), advancing every RUN cycle.
  - Nonzero thr_pattern still selects the fixed pattern.
- Undefined:
  - No LFSR logic.
  - thr_pattern==0 means ready stays low, as specified above.

Decomposition:
- Package fifo_stream_pkg:
  - state enum typedef sink_state_e {IDLE, RUN, DONE}.
  - LFSR seed and tap constants.
  - Default DATA_W/CNT_W localparams, shared with the future stream source block.
- Sub-module fifo_stream_throttle:
  - Owns ptr/LFSR and the registered ready generation.
  - Inputs: load, enable, pattern. Output: rdy.
  - Reused unchanged by the source side for valid throttling.

Test Plan:
- Basic run: start with num_beats=16, first_val=0x00, thr_pattern=0xFF; FIFO fed 0x00..0x0F back-to-back -> data_out_rdy high all 16 transfer cycles; done=1 one cycle after 16th beat; beat_cnt=16, err_cnt=0, first_err_data=0.
- Throttle: thr_pattern=0x55, num_beats=8, FIFO always valid -> ready alternates 1/0 starting high; 8 beats in 15 cycles; no transfer in any ready-low cycle.
- Error capture: expected 0x10..0x13; FIFO sends 0x10,0x11,0x77,0x13 -> err_cnt=1, first_err_data=0x77, beat_cnt=4.
- Wrap: first_val=0xFE, num_beats=4, data 0xFE,0xFF,0x00,0x01 -> err_cnt=0.
- Boundaries:
  - num_beats=0 -> DONE next cycle, ready never high.
  - start pulsed during RUN -> ignored, counters unaffected.
- Reset mid-run: reset low after 5 of 10 beats -> all outputs 0 immediately (asynchronous, before next clk edge), state IDLE; a fresh start completes a clean 10-beat run with err_cnt=0.
